// File: rtl/br_cdc_fifo_push_arb_pkg.sv
// Shared sizing helpers and request type for the CDC FIFO push-port arbiter.
package br_cdc_fifo_push_arb_pkg;

    localparam int unsigned MaxIdxWidth = 8;

    function automatic int unsigned idx_width(input int unsigned num_requesters);
        return (num_requesters > 1) ? $clog2(num_requesters) : 1;
    endfunction

    function automatic int unsigned burst_count_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [MaxIdxWidth-1:0] idx;
    } br_arb_req_t;

endpackage

// File: rtl/br_arb_rr_burst_select.sv
// Combinational next-winner selection: continue the current burst, else round-robin search.
module br_arb_rr_burst_select
    import br_cdc_fifo_push_arb_pkg::*;
#(
    parameter int unsigned NumRequesters   = 2,
    parameter int unsigned MaxBurst        = 1,
    parameter int unsigned IdxWidth        = idx_width(NumRequesters),
    parameter int unsigned BurstCountWidth = burst_count_width(MaxBurst)
) (
    input  logic [NumRequesters-1:0]   req_valid_i,
    input  logic [IdxWidth-1:0]        last_idx_i,
    input  logic [BurstCountWidth-1:0] burst_cnt_i,
    output logic [IdxWidth-1:0]        winner_c_o,
    output logic                       found_c_o
);

    logic        continue_c;
    int unsigned cand_c;

    // A zero count means no burst is open (after reset), so last_idx gets no continuation
    assign continue_c = (burst_cnt_i != '0)
                     && (burst_cnt_i < BurstCountWidth'(MaxBurst))
                     && req_valid_i[last_idx_i];

    always_comb begin
        winner_c_o = last_idx_i;
        found_c_o  = continue_c;
        cand_c     = 0;
        if (!continue_c) begin
            for (int unsigned k = 1; k <= NumRequesters; k++) begin
                cand_c = 32'(last_idx_i) + k;
                if (cand_c >= NumRequesters) begin
                    cand_c = cand_c - NumRequesters;
                end
                if (!found_c_o && req_valid_i[IdxWidth'(cand_c)]) begin
                    found_c_o  = 1'b1;
                    winner_c_o = IdxWidth'(cand_c);
                end
            end
        end
    end

endmodule

// File: rtl/br_cdc_fifo_push_arb.sv
// Round-robin, burst-limited arbiter feeding one CDC FIFO push port through a registered stage.
module br_cdc_fifo_push_arb
    import br_cdc_fifo_push_arb_pkg::*;
#(
    parameter int unsigned NumRequesters                 = 2,
    parameter int unsigned Width                         = 1,
    parameter int unsigned MaxBurst                      = 1,
    parameter bit          EnableAssertReqValidStability = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NumRequesters-1:0]              req_valid,
    input  logic [NumRequesters*Width-1:0]        req_data,
    output logic [NumRequesters-1:0]              req_ready,
    output logic                                  push_valid,
    output logic [Width-1:0]                      push_data,
    output logic [idx_width(NumRequesters)-1:0]   push_owner,
    input  logic                                  push_ready
);

    localparam int unsigned IdxWidth        = idx_width(NumRequesters);
    localparam int unsigned BurstCountWidth = burst_count_width(MaxBurst);

    if (NumRequesters < 2) begin : g_bad_num_requesters
        $error("NumRequesters must be at least 2");
    end
    if (Width < 1) begin : g_bad_width
        $error("Width must be at least 1");
    end
    if (MaxBurst < 1) begin : g_bad_max_burst
        $error("MaxBurst must be at least 1");
    end

    logic                       push_valid_q, push_valid_d;
    logic [Width-1:0]           push_data_q, push_data_d;
    logic [IdxWidth-1:0]        push_owner_q, push_owner_d;
    logic [IdxWidth-1:0]        last_idx_q, last_idx_d;
    logic [BurstCountWidth-1:0] burst_cnt_q, burst_cnt_d;
    logic [IdxWidth-1:0]        winner_c;
    logic                       found_c;
    logic                       load_c;
    logic                       grant_c;
    logic [Width-1:0]           req_data_arr [NumRequesters];

    for (genvar i = 0; i < NumRequesters; i++) begin : g_unpack
        assign req_data_arr[i] = req_data[i*Width +: Width];
    end

    br_arb_rr_burst_select #(
        .NumRequesters  (NumRequesters),
        .MaxBurst       (MaxBurst),
        .IdxWidth       (IdxWidth),
        .BurstCountWidth(BurstCountWidth)
    ) u_select (
        .req_valid_i(req_valid),
        .last_idx_i (last_idx_q),
        .burst_cnt_i(burst_cnt_q),
        .winner_c_o (winner_c),
        .found_c_o  (found_c)
    );

    // The stage may only change when empty or being drained this cycle
    assign load_c  = !push_valid_q || push_ready;
    assign grant_c = load_c && found_c && !rst;

    always_comb begin
        push_valid_d = push_valid_q;
        push_data_d  = push_data_q;
        push_owner_d = push_owner_q;
        last_idx_d   = last_idx_q;
        burst_cnt_d  = burst_cnt_q;
        req_ready    = '0;
        if (load_c) begin
            push_valid_d = 1'b0;
            if (grant_c) begin
                req_ready[winner_c] = 1'b1;
                push_valid_d        = 1'b1;
                push_data_d         = req_data_arr[winner_c];
                push_owner_d        = winner_c;
                if (winner_c == last_idx_q) begin
                    if (burst_cnt_q != BurstCountWidth'(MaxBurst)) begin
                        burst_cnt_d = burst_cnt_q + BurstCountWidth'(1);
                    end
                end else begin
                    last_idx_d  = winner_c;
                    burst_cnt_d = BurstCountWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            push_owner_q <= '0;
            last_idx_q   <= IdxWidth'(NumRequesters - 1);
            burst_cnt_q  <= '0;
        end else begin
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            push_owner_q <= push_owner_d;
            last_idx_q   <= last_idx_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign push_valid = push_valid_q;
    assign push_data  = push_data_q;
    assign push_owner = push_owner_q;

    a_req_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    a_push_stable: assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_data) && $stable(push_owner)));

    if (EnableAssertReqValidStability) begin : g_req_valid_stable
        for (genvar i = 0; i < NumRequesters; i++) begin : g_req
            a_req_valid_stable: assert property (@(posedge clk) disable iff (rst)
                (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
        end
    end

    c_burst_max: cover property (@(posedge clk) disable iff (rst)
        burst_cnt_q == BurstCountWidth'(MaxBurst));

endmodule
